// File: rtl/memory_pkg.sv
// Shared types and constants for the memory arbiter.
//   owner_t     : which requester the in-flight read beat belongs to
//   LED_ADDRESS : MMIO LED register; stores to it pass through the write port
package memory_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_t;

  localparam logic [31:0] LED_ADDRESS = 32'hFFFF_FFFF;

endpackage

// File: rtl/memory_arbiter.sv
// memory_arbiter
//   Shares a single-read/single-write port memory between the fetch unit and
//   the load/store unit. Stores go straight to the write port; loads and
//   fetches compete for the read port (load first, fetch after MAX_WAIT
//   consecutive denials). Read data returns one cycle later and is routed to
//   whichever requester owned the read.
//
// Ports
//   clock, reset_n                     clock, async active-low reset
//   fetch_req_valid/ready/address      fetch read request
//   fetch_rsp_valid/data               fetch read response
//   data_req_valid/ready/write         load/store request
//   data_req_address/wdata/strobe      load/store fields
//   data_rsp_valid/data                load response
//   mem_read_address, mem_read_data    memory read port (1-cycle latency)
//   mem_write_address/data/enable      memory write port (byte enables)
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned MAX_WAIT      = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,

  input  logic                     fetch_req_valid,
  output logic                     fetch_req_ready,
  input  logic [ADDRESS_WIDTH-1:0] fetch_req_address,
  output logic                     fetch_rsp_valid,
  output logic [31:0]              fetch_rsp_data,

  input  logic                     data_req_valid,
  output logic                     data_req_ready,
  input  logic                     data_req_write,
  input  logic [ADDRESS_WIDTH-1:0] data_req_address,
  input  logic [31:0]              data_req_wdata,
  input  logic [3:0]               data_req_strobe,
  output logic                     data_rsp_valid,
  output logic [31:0]              data_rsp_data,

  output logic [ADDRESS_WIDTH-1:0] mem_read_address,
  input  logic [31:0]              mem_read_data,
  output logic [ADDRESS_WIDTH-1:0] mem_write_address,
  output logic [31:0]              mem_write_data,
  output logic [3:0]               mem_write_enable
);

  localparam int unsigned STARVE_WIDTH = $clog2(MAX_WAIT + 1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(MAX_WAIT);

  owner_t                  owner, owner_next;
  logic [STARVE_WIDTH-1:0] starve_count, starve_next;

  logic store_grant;
  logic load_grant;
  logic fetch_grant;
  logic load_request;
  logic same_word;
  logic fetch_blocked;
  logic fetch_urgent;

  // Grant logic, next-state, and request-side outputs.
  always_comb begin
    store_grant       = 1'b0;
    load_grant        = 1'b0;
    fetch_grant       = 1'b0;
    load_request      = data_req_valid && !data_req_write;
    same_word         = (fetch_req_address[ADDRESS_WIDTH-1:2] ==
                         data_req_address[ADDRESS_WIDTH-1:2]);
    fetch_blocked     = 1'b0;
    fetch_urgent      = fetch_req_valid && (starve_count == STARVE_MAX);
    owner_next        = OWNER_NONE;
    starve_next       = starve_count;

    if (reset_n) begin
      store_grant = data_req_valid && data_req_write;
      // A fetch of the word being stored this cycle would read stale data.
      fetch_blocked = store_grant && same_word;
      if (load_request && !fetch_urgent) begin
        load_grant = 1'b1;
      end else if (fetch_req_valid && !fetch_blocked) begin
        fetch_grant = 1'b1;
      end
    end

    if (fetch_grant) begin
      owner_next = OWNER_FETCH;
    end else if (load_grant) begin
      owner_next = OWNER_DATA;
    end

    // Hazard-blocked and priority-denied cycles both count as waiting.
    if (fetch_grant) begin
      starve_next = '0;
    end else if (fetch_req_valid && (starve_count != STARVE_MAX)) begin
      starve_next = starve_count + STARVE_WIDTH'(1);
    end

    fetch_req_ready   = fetch_grant;
    data_req_ready    = store_grant || load_grant;
    mem_read_address  = load_grant ? data_req_address : fetch_req_address;
    mem_write_address = data_req_address;
    mem_write_data    = data_req_wdata;
    mem_write_enable  = store_grant ? data_req_strobe : '0;
  end

  // Owner tag for the beat returning next cycle, plus fetch starvation counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      owner        <= OWNER_NONE;
      starve_count <= '0;
    end else begin
      owner        <= owner_next;
      starve_count <= starve_next;
    end
  end

  assign fetch_rsp_valid = (owner == OWNER_FETCH);
  assign fetch_rsp_data  = mem_read_data;
  assign data_rsp_valid  = (owner == OWNER_DATA);
  assign data_rsp_data   = mem_read_data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Testbench for memory_arbiter: a behavioural memory plus a reference model
// of the arbitration rules; directed scenarios followed by random traffic.
module tb_memory_arbiter;
  import memory_pkg::*;

  localparam int unsigned MAX_WAIT = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fetch_req_valid, fetch_req_ready;
  logic [31:0] fetch_req_address;
  logic        fetch_rsp_valid;
  logic [31:0] fetch_rsp_data;
  logic        data_req_valid, data_req_ready, data_req_write;
  logic [31:0] data_req_address, data_req_wdata;
  logic [3:0]  data_req_strobe;
  logic        data_rsp_valid;
  logic [31:0] data_rsp_data;
  logic [31:0] mem_read_address, mem_read_data;
  logic [31:0] mem_write_address, mem_write_data;
  logic [3:0]  mem_write_enable;

  always #5 clock = ~clock;

  memory_arbiter #(.ADDRESS_WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset_n(reset_n),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_req_address(fetch_req_address),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_data(fetch_rsp_data),
    .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
    .data_req_write(data_req_write), .data_req_address(data_req_address),
    .data_req_wdata(data_req_wdata), .data_req_strobe(data_req_strobe),
    .data_rsp_valid(data_rsp_valid), .data_rsp_data(data_rsp_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable)
  );

  function automatic logic [31:0] pat(input int unsigned i);
    return 32'hC0DE_0000 + i * 32'h0000_0111;
  endfunction

  // Memory: 64 words, address bits [7:2], one-cycle read latency.
  logic        load_mem;
  logic [31:0] mem [64];
  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < 64; i++) mem[i] <= pat(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_write_enable[b]) mem[mem_write_address[7:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    end
    mem_read_data <= mem[mem_read_address[7:2]];
  end

  // Reference model state.
  logic [31:0] ref_mem [64];
  int unsigned m_waited;          // consecutive cycles a valid fetch went ungranted
  int          m_owner;           // 0 none, 1 fetch, 2 data
  logic [31:0] m_rdata;
  logic        last_fg, last_dg;

  // Values observed in the most recent step, for directed constant checks.
  logic        obs_fready, obs_dready, obs_frv, obs_drv;
  logic [31:0] obs_frd, obs_drd, obs_wa;
  logic [3:0]  obs_we;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One clock cycle: inputs are already driven (posedge+1). Checks at negedge,
  // advances the model at posedge, returns at posedge+1.
  task automatic step();
    logic e_store, e_load_req, e_fg, e_lg, urgent, blocked;
    if (!reset_n) begin
      m_owner  = 0;
      m_waited = 0;
    end
    e_store    = reset_n && data_req_valid && data_req_write;
    e_load_req = reset_n && data_req_valid && !data_req_write;
    urgent     = fetch_req_valid && (m_waited >= MAX_WAIT);
    blocked    = e_store && (fetch_req_address >> 2) == (data_req_address >> 2);
    e_lg       = e_load_req && !urgent;
    e_fg       = reset_n && fetch_req_valid && !e_lg && !blocked;

    @(negedge clock);
    check_eq("fetch_ready", {31'd0, fetch_req_ready}, {31'd0, e_fg});
    check_eq("data_ready", {31'd0, data_req_ready}, {31'd0, e_store || e_lg});
    check_eq("write_enable", {28'd0, mem_write_enable}, e_store ? {28'd0, data_req_strobe} : 32'd0);
    if (e_store) begin
      check_eq("write_addr", mem_write_address, data_req_address);
      check_eq("write_data", mem_write_data, data_req_wdata);
    end
    check_eq("fetch_rsp_valid", {31'd0, fetch_rsp_valid}, {31'd0, m_owner == 1});
    check_eq("data_rsp_valid", {31'd0, data_rsp_valid}, {31'd0, m_owner == 2});
    if (m_owner == 1) check_eq("fetch_rsp_data", fetch_rsp_data, m_rdata);
    if (m_owner == 2) check_eq("data_rsp_data", data_rsp_data, m_rdata);
    if (e_fg) check_eq("read_addr_fetch", mem_read_address, fetch_req_address);
    if (e_lg) check_eq("read_addr_data", mem_read_address, data_req_address);
    obs_fready = fetch_req_ready;  obs_dready = data_req_ready;
    obs_frv    = fetch_rsp_valid;  obs_drv    = data_rsp_valid;
    obs_frd    = fetch_rsp_data;   obs_drd    = data_rsp_data;
    obs_we     = mem_write_enable; obs_wa     = mem_write_address;
    last_fg    = e_fg;
    last_dg    = e_store || e_lg;

    @(posedge clock);
    if (load_mem) begin
      for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    end
    if (reset_n) begin
      if (e_store)
        for (int b = 0; b < 4; b++)
          if (data_req_strobe[b]) ref_mem[data_req_address[7:2]][8*b +: 8] = data_req_wdata[8*b +: 8];
      m_owner = 0;
      if (e_fg) begin
        m_owner = 1;
        m_rdata = ref_mem[fetch_req_address[7:2]];
      end else if (e_lg) begin
        m_owner = 2;
        m_rdata = ref_mem[data_req_address[7:2]];
      end
      if (e_fg) m_waited = 0;
      else if (fetch_req_valid && m_waited < MAX_WAIT) m_waited++;
    end
    #1;
  endtask

  task automatic set_fetch(input logic v, input logic [31:0] a);
    fetch_req_valid = v; fetch_req_address = a;
  endtask

  task automatic set_data(input logic v, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
    data_req_valid = v; data_req_write = w; data_req_address = a;
    data_req_wdata = d; data_req_strobe = s;
  endtask

  initial begin
    m_owner = 0; m_waited = 0; m_rdata = '0;
    load_mem = 1'b1;
    reset_n  = 1'b0;
    set_fetch(1'b1, 32'h10);
    set_data(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    #1;

    // Reset held with both requests valid.
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("rst_fetch_ready", {31'd0, obs_fready}, 32'd0);
      check_eq("rst_data_ready", {31'd0, obs_dready}, 32'd0);
      check_eq("rst_we", {28'd0, obs_we}, 32'd0);
      check_eq("rst_rsp", {30'd0, obs_frv, obs_drv}, 32'd0);
    end
    load_mem = 1'b0;
    reset_n  = 1'b1;
    set_fetch(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();

    // Back-to-back fetches of words 0..2.
    for (int i = 0; i < 4; i++) begin
      if (i < 3) set_fetch(1'b1, 32'(i * 4));
      else       set_fetch(1'b0, 32'h0);
      step();
      if (i < 3) check_eq("seq_fetch_ready", {31'd0, obs_fready}, 32'd1);
      if (i > 0) begin
        check_eq("seq_rsp_valid", {31'd0, obs_frv}, 32'd1);
        check_eq("seq_rsp_data", obs_frd, pat(i - 1));
      end
    end

    // Fetch starved by loads until MAX_WAIT denials accumulate.
    set_fetch(1'b1, 32'h10);
    set_data(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    for (int c = 0; c < 6; c++) begin
      step();
      check_eq("starve_fetch_ready", {31'd0, obs_fready}, {31'd0, c == 4});
      check_eq("starve_data_ready", {31'd0, obs_dready}, {31'd0, c != 4});
    end
    set_fetch(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check_eq("starve_last_rsp", obs_drd, pat(8));

    // Fetch hitting the word being stored is held off one cycle.
    set_fetch(1'b1, 32'h40);
    set_data(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    step();
    check_eq("hazard_store_ready", {31'd0, obs_dready}, 32'd1);
    check_eq("hazard_fetch_ready", {31'd0, obs_fready}, 32'd0);
    set_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check_eq("hazard_retry_ready", {31'd0, obs_fready}, 32'd1);
    set_fetch(1'b0, 32'h0);
    step();
    check_eq("hazard_rsp_data", obs_frd, 32'hDEAD_BEEF);

    // Store and fetch to different words proceed together.
    set_fetch(1'b1, 32'h80);
    set_data(1'b1, 1'b1, 32'h44, 32'h1234_5678, 4'hF);
    step();
    check_eq("dual_ready", {30'd0, obs_fready, obs_dready}, 32'd3);
    check_eq("dual_we", {28'd0, obs_we}, 32'hF);
    set_fetch(1'b0, 32'h0);
    set_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check_eq("dual_rsp_data", obs_frd, pat(32));

    // LED MMIO store passes through; then load-after-store to one word.
    set_data(1'b1, 1'b1, LED_ADDRESS, 32'h0000_0001, 4'h1);
    step();
    check_eq("led_addr", obs_wa, LED_ADDRESS);
    set_data(1'b1, 1'b1, 32'h50, 32'hCAFE_F00D, 4'h3);
    step();
    set_data(1'b1, 1'b0, 32'h50, 32'h0, 4'h0);
    step();
    set_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    step();
    check_eq("las_rsp_data", obs_drd, {pat(20) >> 16, 16'hF00D});

    // Reset while a load response is pending drops it.
    set_data(1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
    step();
    set_data(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    reset_n = 1'b0;
    #1;
    check_eq("rst_drop_valid", {31'd0, data_rsp_valid}, 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("rst_drop_after", {30'd0, obs_frv, obs_drv}, 32'd0);

    // Random traffic; requesters hold fields while waiting.
    for (int c = 0; c < 400; c++) begin
      if (!(fetch_req_valid && !last_fg))
        set_fetch($urandom_range(0, 9) < 7, 32'($urandom_range(0, 15)) << 2);
      if (!(data_req_valid && !last_dg)) begin
        if ($urandom_range(0, 19) == 0)
          set_data(1'b1, 1'b1, LED_ADDRESS, $urandom, 4'($urandom_range(0, 15)));
        else
          set_data($urandom_range(0, 9) < 6, 1'($urandom), 32'($urandom_range(0, 15)) << 2,
                   $urandom, 4'($urandom_range(0, 15)));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
